// File: rtl/load_store_unit.sv
// load_store_unit: M-stage load/store unit driving a req/gnt/rvalid data bus.
// Builds byte enables and lane-replicated store data, and sign/zero-extends load data.
// Holds the pipeline stalled until the access retires, and times out hung accesses.
// Optional feature: define MISALIGN_EXC_EN to make misaligned accesses skip the bus
// and report o_misalign. The default build forces such accesses into alignment.
module load_store_unit #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_req_valid,
   input  logic                    i_we,
   input  logic [2:0]              i_funct3,
   input  logic [DATA_WIDTH-1:0]   i_addr,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   output logic                    o_stall,
   output logic                    o_load_valid,
   output logic [DATA_WIDTH-1:0]   o_load_data,
   output logic                    o_misalign,
   output logic                    o_bus_err,
   output logic                    o_mem_req,
   output logic                    o_mem_we,
   output logic [DATA_WIDTH-1:0]   o_mem_addr,
   output logic [DATA_WIDTH-1:0]   o_mem_wdata,
   output logic [DATA_WIDTH/8-1:0] o_mem_be,
   input  logic                    i_mem_gnt,
   input  logic                    i_mem_rvalid,
   input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

   localparam int unsigned DW      = DATA_WIDTH;
   localparam int unsigned NB      = DW / 8;
   localparam int unsigned OFF_W   = $clog2(NB);
   localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYCLES + 2);
   localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [1:0]  FULL_SZ = 2'(OFF_W);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

   // log2 of the access size in bytes; unsupported encodings become full width
   function automatic logic [1:0] acc_size(input logic we, input logic [2:0] f3);
      logic full;
      full = (we && f3[2]) || (f3 == 3'b111) ||
             ((DW == 32) && ((f3[1:0] == 2'b11) || (f3 == 3'b110)));
      return full ? FULL_SZ : f3[1:0];
   endfunction

   // offset bits that lie below the access size
   function automatic logic [OFF_W-1:0] low_mask(input logic [1:0] sz);
      return (OFF_W'(1) << sz) - OFF_W'(1);
   endfunction

   function automatic logic [NB-1:0] byte_en(input logic [1:0] sz, input logic [OFF_W-1:0] off);
      logic [NB-1:0] m;
      case (sz)
         2'd0:    m = NB'(1);
         2'd1:    m = NB'(3);
         2'd2:    m = NB'(15);
         default: m = '1;
      endcase
      if (sz == FULL_SZ) m = '1;
      return m << off;
   endfunction

   function automatic logic [DW-1:0] replicate(input logic [1:0] sz, input logic [DW-1:0] w);
      logic [DW-1:0] r;
      case (sz)
         2'd0:    r = {NB{w[7:0]}};
         2'd1:    r = {(NB/2){w[15:0]}};
         2'd2:    r = {(NB/4){w[31:0]}};
         default: r = w;
      endcase
      if (sz == FULL_SZ) r = w;
      return r;
   endfunction

   function automatic logic [DW-1:0] extend(input logic [1:0] sz, input logic uns,
                                            input logic [DW-1:0] rd, input logic [OFF_W-1:0] off);
      logic [DW-1:0] sh;
      logic [DW-1:0] r;
      sh = rd >> {off, 3'b000};
      case (sz)
         2'd0:    r = uns ? DW'(sh[7:0])  : DW'($signed(sh[7:0]));
         2'd1:    r = uns ? DW'(sh[15:0]) : DW'($signed(sh[15:0]));
         2'd2:    r = uns ? DW'(sh[31:0]) : DW'($signed(sh[31:0]));
         default: r = sh;
      endcase
      if (sz == FULL_SZ) r = sh;
      return r;
   endfunction

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [OFF_W-1:0]    off_q, off_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [DW-1:0]       mem_addr_q, mem_addr_d;
   logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
   logic [NB-1:0]       mem_be_q, mem_be_d;
   logic                load_valid_q, load_valid_d;
   logic [DW-1:0]       load_data_q, load_data_d;
   logic                bus_err_q, bus_err_d;
   logic                misalign_q, misalign_d;

   logic [1:0]          in_sz;
   logic [OFF_W-1:0]    in_off;
   logic                go_misal;
   logic [1:0]          q_sz;
   logic                timeout;
   logic [CNT_W-1:0]    cnt_inc;

   // decode of the incoming access and of the captured load
   assign in_sz   = acc_size(i_we, i_funct3);
   assign in_off  = i_addr[OFF_W-1:0] & ~low_mask(in_sz);
   assign q_sz    = acc_size(we_q, funct3_q);
   assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q >= CNT_W'(TO_LAST));
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef MISALIGN_EXC_EN
   assign go_misal = |(i_addr[OFF_W-1:0] & low_mask(in_sz));
`else
   assign go_misal = 1'b0;
`endif

   // next-state, bus request and response pulses
   always_comb begin
      state_d      = state_q;
      cnt_d        = '0;
      we_d         = we_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      mem_req_d    = 1'b0;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_be_d     = mem_be_q;
      load_valid_d = 1'b0;
      load_data_d  = load_data_q;
      bus_err_d    = 1'b0;
      misalign_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_req_valid) begin
               we_d     = i_we;
               funct3_d = i_funct3;
               off_d    = i_addr[OFF_W-1:0];
               if (go_misal) begin
                  state_d     = S_RESP;
                  misalign_d  = 1'b1;
                  load_data_d = '0;
               end else begin
                  state_d     = S_REQ;
                  mem_req_d   = 1'b1;
                  mem_we_d    = i_we;
                  mem_addr_d  = {i_addr[DW-1:OFF_W], OFF_W'(0)};
                  mem_be_d    = byte_en(in_sz, in_off);
                  mem_wdata_d = replicate(in_sz, i_wdata);
               end
            end
         end
         S_REQ: begin
            cnt_d = cnt_inc;
            if (i_mem_gnt) begin
               state_d = we_q ? S_RESP : S_WAIT;
            end else if (timeout) begin
               state_d     = S_RESP;
               bus_err_d   = 1'b1;
               load_data_d = '0;
            end else begin
               mem_req_d = 1'b1;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_inc;
            if (i_mem_rvalid) begin
               state_d      = S_RESP;
               load_valid_d = 1'b1;
               load_data_d  = extend(q_sz, funct3_q[2], i_mem_rdata, off_q & ~low_mask(q_sz));
            end else if (timeout) begin
               state_d     = S_RESP;
               bus_err_d   = 1'b1;
               load_data_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         funct3_q     <= '0;
         off_q        <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= '0;
         load_valid_q <= 1'b0;
         load_data_q  <= '0;
         bus_err_q    <= 1'b0;
         misalign_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
         load_valid_q <= load_valid_d;
         load_data_q  <= load_data_d;
         bus_err_q    <= bus_err_d;
         misalign_q   <= misalign_d;
      end
   end

   // the stall must rise in the same cycle the M stage presents an access
   assign o_stall      = ((state_q == S_IDLE) && i_req_valid) ||
                         (state_q == S_REQ) || (state_q == S_WAIT);
   assign o_load_valid = load_valid_q;
   assign o_load_data  = load_data_q;
   assign o_bus_err    = bus_err_q;
   assign o_misalign   = misalign_q;
   assign o_mem_req    = mem_req_q;
   assign o_mem_we     = mem_we_q;
   assign o_mem_addr   = mem_addr_q;
   assign o_mem_wdata  = mem_wdata_q;
   assign o_mem_be     = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit (DATA_WIDTH=32, TIMEOUT_CYCLES=8).
module tb_load_store_unit;

   localparam int unsigned DW = 32;
   localparam int          TO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req_valid, i_we;
   logic [2:0]    i_funct3;
   logic [31:0]   i_addr, i_wdata;
   logic          o_stall, o_load_valid, o_misalign, o_bus_err;
   logic [31:0]   o_load_data;
   logic          o_mem_req, o_mem_we;
   logic [31:0]   o_mem_addr, o_mem_wdata;
   logic [3:0]    o_mem_be;
   logic          i_mem_gnt, i_mem_rvalid;
   logic [31:0]   i_mem_rdata;

   load_store_unit #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .i_we(i_we), .i_funct3(i_funct3),
      .i_addr(i_addr), .i_wdata(i_wdata),
      .o_stall(o_stall), .o_load_valid(o_load_valid), .o_load_data(o_load_data),
      .o_misalign(o_misalign), .o_bus_err(o_bus_err),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
      .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // response queue: {load_valid, bus_err, misalign, load_data}
   logic [34:0] rq[$];
   // bus queue: {we, addr, be, wdata}
   logic [68:0] bq[$];

   int          gnt_dly_cfg = 0;
   int          rv_dly_cfg  = 1;
   logic [31:0] rdata_cfg   = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int nbytes_of(input logic we, input logic [2:0] f3);
      if (we && f3[2]) return 4;
      if (f3 == 3'b111 || f3 == 3'b110) return 4;
      case (f3[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   // reference: bytewise lane selection and extension
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        output logic [31:0] maddr, output logic [3:0] be,
                        output logic [31:0] wd, output logic [31:0] ld, output logic mis);
      int n, off, aoff;
      n     = nbytes_of(we, f3);
      off   = int'(addr & 32'h3);
      mis   = (off % n) != 0;
      aoff  = off - (off % n);
      maddr = addr & ~32'h3;
      be    = '0;
      for (int i = 0; i < n; i++) be[aoff+i] = 1'b1;
      wd = '0;
      for (int j = 0; j < 4; j++) wd[8*j +: 8] = wdata[8*(j % n) +: 8];
      ld = rdata >> (8 * aoff);
      if (n < 4)
         for (int b = 8 * n; b < 32; b++) ld[b] = f3[2] ? 1'b0 : ld[8*n-1];
   endtask

   // bus responder: gnt after gnt_dly_cfg req cycles, rvalid rv_dly_cfg cycles after gnt
   initial begin
      int req_cnt = 0;
      int rv_cnt  = 0;
      i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         i_mem_rvalid = 1'b0;
         i_mem_rdata  = $urandom;
         if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
               i_mem_rvalid = 1'b1;
               i_mem_rdata  = rdata_cfg;
            end
         end
         if (o_mem_req) begin
            i_mem_gnt = (req_cnt == gnt_dly_cfg);
            if (i_mem_gnt && !o_mem_we && rv_dly_cfg > 0) rv_cnt = rv_dly_cfg;
            req_cnt++;
         end else begin
            req_cnt   = 0;
            i_mem_gnt = ($urandom_range(0, 3) == 0);
         end
      end
   end

   // monitor: bus request contents and response pulses
   initial begin
      forever begin
         @(negedge clk);
         if (o_mem_req) begin
            if (bq.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_mem_req: got addr 0x%08h expected no request", o_mem_addr);
            end else begin
               check("mem_we",    32'(o_mem_we),    32'(bq[0][68]));
               check("mem_addr",  o_mem_addr,       bq[0][67:36]);
               check("mem_be",    32'(o_mem_be),    32'(bq[0][35:32]));
               check("mem_wdata", o_mem_wdata,      bq[0][31:0]);
               if (i_mem_gnt) void'(bq.pop_front());
            end
         end
         if (o_load_valid || o_bus_err || o_misalign) begin
            if (rq.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_resp: got flags %b%b%b expected none",
                        o_load_valid, o_bus_err, o_misalign);
            end else begin
               logic [34:0] e;
               e = rq.pop_front();
               check("resp_flags", 32'({o_load_valid, o_bus_err, o_misalign}), 32'(e[34:32]));
               check("load_data",  o_load_data, e[31:0]);
            end
         end
      end
   end

   // one access from presentation to retirement; gdly<0 = never grant, rdly<=0 = never rvalid
   task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata,
                      input int gdly, input int rdly);
      logic [31:0] maddr, wd, ld;
      logic [3:0]  be;
      logic        mis;
      int          need, exp_stall, stalls;
      bit          to, on_bus;
      model(we, f3, addr, wdata, rdata, maddr, be, wd, ld, mis);
      on_bus = 1'b1;
      to     = 1'b0;
`ifdef MISALIGN_EXC_EN
      if (mis) on_bus = 1'b0;
`endif
      if (!on_bus) begin
         rq.push_back({3'b001, 32'h0});
         exp_stall = 1;
      end else begin
         bq.push_back({we, maddr, be, wd});
         need = (gdly + 1) + (we ? 0 : rdly);
         to   = (gdly < 0) || (!we && rdly <= 0) || (need > TO);
         if (to) begin
            rq.push_back({3'b010, 32'h0});
            exp_stall = 1 + TO;
         end else begin
            if (!we) rq.push_back({3'b100, ld});
            exp_stall = 1 + need;
         end
      end
      gnt_dly_cfg = gdly; rv_dly_cfg = rdly; rdata_cfg = rdata;
      i_req_valid = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
      stalls = 0;
      forever begin
         @(negedge clk);
         if (!o_stall) break;
         stalls++;
         if (stalls > 40) begin
            total++; bad++;
            $display("FAIL stall_bound: got >40 stall cycles expected %0d", exp_stall);
            break;
         end
         @(posedge clk); #1;
      end
      check("stall_cycles", 32'(stalls), 32'(exp_stall));
      if (to) check("req_drop", 32'(o_mem_req), 32'h0);
      if (on_bus && gdly < 0 && bq.size() > 0) void'(bq.pop_front());
      i_req_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; i_req_valid = 1'b0; i_we = 1'b0; i_funct3 = '0; i_addr = '0; i_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stall",      32'(o_stall),      32'h0);
      check("rst_load_valid", 32'(o_load_valid), 32'h0);
      check("rst_load_data",  o_load_data,       32'h0);
      check("rst_bus_err",    32'(o_bus_err),    32'h0);
      check("rst_misalign",   32'(o_misalign),   32'h0);
      check("rst_mem_req",    32'(o_mem_req),    32'h0);
      check("rst_mem_we",     32'(o_mem_we),     32'h0);
      check("rst_mem_addr",   o_mem_addr,        32'h0);
      check("rst_mem_wdata",  o_mem_wdata,       32'h0);
      check("rst_mem_be",     32'(o_mem_be),     32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // directed cases
      run(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0,         0, 1);   // SB
      run(1'b0, 3'b000, 32'h101, 32'h0,         32'h0000_F000, 0, 1);   // LB
      run(1'b0, 3'b100, 32'h101, 32'h0,         32'h0000_F000, 0, 1);   // LBU
      run(1'b0, 3'b001, 32'h102, 32'h0,         32'h8001_0000, 3, 1);   // LH, late gnt
      run(1'b0, 3'b010, 32'h104, 32'h0,         32'h1234_5678, 0, 10);  // LW timeout in WAIT
      repeat (6) @(posedge clk);
      #1;
      run(1'b0, 3'b010, 32'h102, 32'h0,         32'hCAFE_F00D, 0, 1);   // misaligned LW
      run(1'b1, 3'b010, 32'h108, 32'hDEAD_BEEF, 32'h0,        -1, 1);   // SW timeout in REQ
      run(1'b1, 3'b001, 32'h10E, 32'h0000_1234, 32'h0,         1, 1);   // SH upper half
      run(1'b0, 3'b101, 32'h10E, 32'h0,         32'hF00F_0000, 0, 2);   // LHU

      // reset during WAIT; the later rvalid must be ignored
      bq.push_back({1'b0, 32'h110, 4'hF, 32'h0});
      gnt_dly_cfg = 0; rv_dly_cfg = 4; rdata_cfg = 32'h5555_AAAA;
      i_req_valid = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h110; i_wdata = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; i_req_valid = 1'b0;
      @(negedge clk);
      check("rst_wait_mem_req", 32'(o_mem_req), 32'h0);
      check("rst_wait_stall",   32'(o_stall),   32'h0);
      repeat (6) @(posedge clk);
      #1;
      run(1'b0, 3'b010, 32'h114, 32'h0, 32'h0BAD_F00D, 0, 1);

      // randomized accesses
      for (int k = 0; k < 80; k++) begin
         logic [2:0]  f3;
         logic        we;
         logic [31:0] a;
         f3 = 3'($urandom_range(0, 7));
         we = 1'($urandom_range(0, 1));
         a  = 32'h100 + 32'($urandom_range(0, 63));
         run(we, f3, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
      end

      repeat (10) @(posedge clk);
      check("rq_empty", 32'(rq.size()), 32'h0);
      check("bq_empty", 32'(bq.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
